mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Parametrised iterative multiply/divide unit with architectural HI/LO registers built in.
//  It sits beside the ALU in the datapath and serves MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//  Control issues one start pulse, then waits on busy/done. HI/LO are updated only on completion.
//  Compared with the previous DIVMULT+HI/LO pair it adds:
//   - a width parameter
//   - an optional signed mode
//   - a handshake
//   - direct HI/LO writes
// PARAMETERS
//  WIDTH  32  operand/HI/LO width in bits; even, >= 4
// PORTS
//  clk      in   1      clock, rising edge
//  reset    in   1      synchronous reset, active-high
//  start    in   1      launch op; sampled only in IDLE
//  op       in   1      0 = multiply, 1 = divide
//  sgn      in   1      1 = signed operands (see CONFIGURATION)
//  a        in   WIDTH  multiplicand / dividend, captured at start
//  b        in   WIDTH  multiplier / divisor, captured at start
//  wr_hi    in   1      write wdata into HI (MTHI)
//  wr_lo    in   1      write wdata into LO (MTLO)
//  wdata    in   WIDTH  data for wr_hi / wr_lo
//  busy     out  1      high while an op is in flight
//  done     out  1      one-cycle pulse: result now visible on hi/lo
//  div0     out  1      last divide had b == 0; held until next accepted start
//  hi       out  WIDTH  HI register: product[2W-1:W] or remainder
//  lo       out  WIDTH  LO register: product[W-1:0] or quotient
// BEHAVIOUR
//  Reset values: all outputs = 0; state = IDLE.
//  States: IDLE -> RUN -> FIN -> IDLE.
//   - IDLE: start=1 captures a, b, op, sgn, clears div0, loads the iteration counter = WIDTH.
//     Goes to RUN, or to FIN directly if op=1 and b=0.
//   - RUN: one shift-add (mult) or restoring shift-subtract (div) step per cycle.
//     Lasts exactly WIDTH cycles, then goes to FIN.
//   - FIN: registers the result into hi/lo (sign fix-up applied), pulses done=1, returns to IDLE.
//  Latency: start sampled at edge E -> busy=1 from E+1. done=1 and new hi/lo visible at E+WIDTH+2.
//   busy=0 in the done cycle; a new start is accepted in that same cycle.
//  Divide-by-zero: no RUN. div0=1 and done=1 at E+2. hi/lo keep their previous values.
//  Divide results: lo = quotient, hi = remainder.
//   - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
//   - Signed -2^(W-1) / -1: lo = -2^(W-1), hi = 0 (wraps, no flag).
//  Multiply result: full 2*WIDTH product, no overflow flag.
//  start while busy: ignored; no queueing, captured operands untouched.
//  wr_hi / wr_lo:
//   - Honoured only in IDLE with start=0; take effect the next edge.
//   - Ignored while busy, and ignored in the same cycle as an accepted start (start wins).
//   - wr_hi and wr_lo together: both registers load wdata.
//  Reset mid-operation: abandons the op. Next cycle: busy=done=div0=0, hi=lo=0, state IDLE.
//  Operand inputs may change freely after the start cycle.
// CONFIGURATION
//  MDU_SIGNED_EN defined:
//   - sgn honoured; signed mult/div done as magnitude iteration plus sign correction in FIN.
//  MDU_SIGNED_EN undefined:
//   - sgn ignored, all ops unsigned, no sign logic synthesised.
//   - Latency is identical in both builds.
// TESTING (WIDTH=32)
//  1. mult a=FFFFFFFF b=2 sgn=0
//     -> done at E+34, hi=00000001, lo=FFFFFFFE, busy high for exactly 33 cycles.
//  2. [MDU_SIGNED_EN] mult a=-3 b=5 sgn=1 -> hi=FFFFFFFF, lo=FFFFFFF1.
//     Without the macro: hi=00000004, lo=FFFFFFF1.
//  3. div a=7 b=2 sgn=0 -> lo=3, hi=1.
//     [MDU_SIGNED_EN] a=-7 b=2 sgn=1 -> lo=FFFFFFFD, hi=FFFFFFFF.
//  4. wr_hi wdata=AAAA5555, then div a=10 b=0
//     -> div0=1, done at E+2, hi=AAAA5555, lo unchanged; div0 clears on the next start.
//  5. mult started, reset at RUN cycle 10 -> next cycle all outputs 0, IDLE.
//     A following div 100/7 -> lo=14, hi=2.
//  6. start + wr_lo pulsed while busy -> both ignored; original result delivered.
//     start+wr_lo in an IDLE cycle -> op runs, LO not written from wdata.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with built-in HI/LO registers.
// Define MDU_SIGNED_EN to honour sgn (magnitude iteration plus sign fix-up in FIN).
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   m;
  logic [CW-1:0]      cnt;
  logic               op_q;
  logic               dz_q;

  logic [WIDTH-1:0]   amag;
  logic [WIDTH-1:0]   bmag;
  logic [2*WIDTH-1:0] pres;
  logic [WIDTH-1:0]   qres;
  logic [WIDTH-1:0]   rres;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     t;
  logic [WIDTH:0]     diff;

`ifdef MDU_SIGNED_EN
  logic an;
  logic bn;
  logic neg_q;
  logic rneg_q;

  assign an   = sgn & a[WIDTH-1];
  assign bn   = sgn & b[WIDTH-1];
  assign amag = an ? -a : a;
  assign bmag = bn ? -b : b;
  assign pres = neg_q ? -p : p;
  assign qres = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
  assign rres = rneg_q ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
`else
  logic unused_sgn;

  assign unused_sgn = sgn;
  assign amag = a;
  assign bmag = b;
  assign pres = p;
  assign qres = p[WIDTH-1:0];
  assign rres = p[2*WIDTH-1:WIDTH];
`endif

  // p holds {acc, multiplier} for mult and {remainder, quotient} for div
  assign sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
  assign t    = p[2*WIDTH-1:WIDTH-1];
  assign diff = t - {1'b0, m};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      div0  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      p     <= '0;
      m     <= '0;
      cnt   <= '0;
      op_q  <= 1'b0;
      dz_q  <= 1'b0;
`ifdef MDU_SIGNED_EN
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            dz_q  <= op && (b == '0);
            m     <= bmag;
            p     <= {{WIDTH{1'b0}}, amag};
            cnt   <= CW'(WIDTH);
            div0  <= 1'b0;
            busy  <= 1'b1;
            state <= (op && (b == '0)) ? FIN : RUN;
`ifdef MDU_SIGNED_EN
            neg_q  <= an ^ bn;
            rneg_q <= an;
`endif
          end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
          end
        end
        RUN: begin
          if (op_q) begin
            p <= diff[WIDTH]
               ? {t[WIDTH-1:0], p[WIDTH-2:0], 1'b0}
               : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
          end else begin
            p <= {sum, p[WIDTH-1:1]};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIN;
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (dz_q) begin
            div0 <= 1'b1;
          end else if (op_q) begin
            hi <= rres;
            lo <= qres;
          end else begin
            {hi, lo} <= pres;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
